// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump unit.
package regfile_dump_pkg;

  localparam int REG_SELECT_WIDTH = 3;
  localparam int DATA_WIDTH       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_unit.sv
// Walks every register through one read port and streams {index, value}
// over valid/ready while summing accepted words into a checksum.
module regfile_dump_unit #(
  parameter int REG_SELECT_WIDTH = regfile_dump_pkg::REG_SELECT_WIDTH,
  parameter int DATA_WIDTH       = regfile_dump_pkg::DATA_WIDTH
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Abort,
  output logic [REG_SELECT_WIDTH-1:0] ReadSelect,
  input  logic [DATA_WIDTH-1:0]       ReadData,
  output logic [DATA_WIDTH-1:0]       OutData,
  output logic [REG_SELECT_WIDTH-1:0] OutIndex,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic                        Busy,
  output logic                        Done,
  output logic [DATA_WIDTH-1:0]       Checksum
);

  import regfile_dump_pkg::*;

  state_e                      state_q, state_d;
  logic [REG_SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [REG_SELECT_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [DATA_WIDTH-1:0]       sum_q, sum_d;
  logic                        valid_q, valid_d;
  logic                        hs;
  logic                        last;

  assign hs   = valid_q & OutReady;
  assign last = &idx_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          state_d = READ;
          sel_d   = '0;
          sum_d   = '0;
        end
      end
      READ: begin
        if (Abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          data_d  = ReadData;
          idx_d   = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // An accepted word counts even when Abort lands on the same edge
        if (hs) sum_d = sum_q + data_q;
        if (Abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (hs) begin
          valid_d = 1'b0;
          if (last) begin
            state_d = DONE;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign ReadSelect = sel_q;
  assign OutIndex   = idx_q;
  assign OutData    = data_q;
  assign OutValid   = valid_q;
  assign Checksum   = sum_q;
  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Randomized and directed checks of regfile_dump_unit against a
// dump-progress model; the register file is a plain array here.
module tb_regfile_dump_unit;

  localparam int RW = 3;
  localparam int DW = 32;
  localparam int N  = 1 << RW;

  logic          Clk = 1'b0;
  logic          Reset, Start, Abort, OutReady;
  logic [RW-1:0] ReadSelect, OutIndex;
  logic [DW-1:0] ReadData, OutData, Checksum;
  logic          OutValid, Busy, Done;

  logic [DW-1:0] rf [N];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  assign ReadData = rf[ReadSelect];

  always #5 Clk = ~Clk;

  regfile_dump_unit #(.REG_SELECT_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .ReadSelect(ReadSelect), .ReadData(ReadData),
    .OutData(OutData), .OutIndex(OutIndex), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: tracks dump progress (which index is next, whether a word is
  // on offer, running sum) rather than any state encoding.
  bit            m_busy, m_valid, m_pend, m_done;
  int            m_idx;
  logic [DW-1:0] m_data, m_sum;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_busy <= 0; m_valid <= 0; m_pend <= 0; m_done <= 0;
      m_idx  <= 0; m_data  <= '0; m_sum <= '0;
    end else if (m_done) begin
      m_done <= 0; m_busy <= 0;
    end else if (!m_busy) begin
      if (Start && !Abort) begin
        m_busy <= 1; m_pend <= 1; m_idx <= 0; m_sum <= '0;
      end
    end else begin
      if (m_valid && OutReady) m_sum <= m_sum + m_data;
      if (Abort) begin
        m_busy <= 0; m_valid <= 0; m_pend <= 0;
      end else if (m_valid && OutReady) begin
        m_valid <= 0;
        if (m_idx == N - 1) m_done <= 1;
        else begin
          m_idx <= m_idx + 1; m_pend <= 1;
        end
      end else if (m_pend) begin
        m_pend <= 0; m_valid <= 1; m_data <= rf[m_idx];
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", DW'(Busy), DW'(m_busy));
      check("done", DW'(Done), DW'(m_done));
      check("valid", DW'(OutValid), DW'(m_valid));
      check("checksum", Checksum, m_sum);
      if (m_valid) begin
        check("out_data", OutData, m_data);
        check("out_index", DW'(OutIndex), DW'(m_idx));
      end
      if (m_pend) check("read_select", DW'(ReadSelect), DW'(m_idx));
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic pulse_start();
    Start = 1; tick(); Start = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!Done && n < budget) begin tick(); n++; end
    check({name, "_done_seen"}, DW'(Done), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    bit seen;
    Reset = 0; Start = 0; Abort = 0; OutReady = 0;
    for (int i = 0; i < N; i++) rf[i] = '0;
    tick(); tick();
    check("rst_sel", DW'(ReadSelect), 0);
    check("rst_data", OutData, 0);
    check("rst_idx", DW'(OutIndex), 0);
    check("rst_sum", Checksum, 0);
    check("rst_ctl", DW'({OutValid, Busy, Done}), 0);
    Reset = 1;
    chk_en = 1;
    tick();

    // Full dump with OutReady held high
    rf[0] = 32'hDEADBEEF; rf[1] = 32'hBADF000D;
    OutReady = 1;
    pulse_start();
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Busy) busy_cnt++;
      if (Done) seen = 1; else tick();
    end
    check("full_done_seen", DW'(seen), 1);
    check("full_busy_cycles", busy_cnt, 2 * N + 1);
    check("full_sum", Checksum, 32'h998CBEFC);
    tick();
    check("full_idle", DW'({Busy, Done}), 0);
    check("full_sum_hold", Checksum, 32'h998CBEFC);

    // Backpressure: OutReady alternates every cycle
    OutReady = 0;
    pulse_start();
    for (int i = 0; i < 80 && !Done; i++) begin
      OutReady = ~OutReady; tick();
    end
    check("bp_done", DW'(Done), 1);
    check("bp_sum", Checksum, 32'h998CBEFC);
    tick();

    // Abort while index 3 is on offer and not accepted
    OutReady = 1;
    pulse_start();
    for (int i = 0; i < 40 && !(OutValid && OutIndex == 3); i++) tick();
    check("abort_reach_idx3", DW'(OutValid && OutIndex == 3), 1);
    OutReady = 0; Abort = 1; tick(); Abort = 0;
    check("abort_ctl", DW'({OutValid, Busy, Done}), 0);
    check("abort_sum", Checksum, 32'h998CBEFC);
    tick();
    check("abort_no_done", DW'(Done), 0);

    // Reset during READ of index 5, then a fresh dump from index 0
    OutReady = 1;
    pulse_start();
    for (int i = 0; i < 40 && !(Busy && !OutValid && ReadSelect == 5); i++)
      tick();
    check("rst_mid_reach", DW'(ReadSelect), 5);
    Reset = 0; tick(); Reset = 1;
    check("rstm_sel", DW'(ReadSelect), 0);
    check("rstm_out", OutData | DW'(OutIndex), 0);
    check("rstm_ctl", DW'({OutValid, Busy, Done}), 0);
    check("rstm_sum", Checksum, 0);
    pulse_start();
    for (int i = 0; i < 5 && !OutValid; i++) tick();
    check("rstm_first_idx", DW'(OutIndex), 0);
    wait_done(40, "rstm");
    tick();

    // Start pulses mid-dump must not restart it
    pulse_start();
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Busy) busy_cnt++;
      if (Done) seen = 1;
      else begin Start = (i % 3 == 1); tick(); end
    end
    Start = 0;
    check("sb_busy_cycles", busy_cnt, 2 * N + 1);
    tick();

    // Start and Abort together in IDLE
    Start = 1; Abort = 1; tick(); Start = 0; Abort = 0;
    check("sa_idle_busy", DW'(Busy), 0);
    tick();
    check("sa_idle_busy2", DW'(Busy), 0);

    // Randomized traffic; register contents change only while idle
    for (int c = 0; c < 4000; c++) begin
      if (!Busy)
        for (int i = 0; i < N; i++) rf[i] = $urandom;
      OutReady = ($urandom_range(0, 3) != 0);
      Start    = ($urandom_range(0, 7) == 0);
      Abort    = ($urandom_range(0, 59) == 0);
      Reset    = ($urandom_range(0, 299) != 0);
      tick();
    end
    Start = 0; Abort = 0; Reset = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
